// File: rtl/circuit2_pipe_pkg.sv
// circuit2_pipe_pkg
//   Shared definitions for the circuit2_pipe datapath.
//   - NSTAGES : number of registered pipeline stages.
//   - sel_e   : mux-select encoding. Every datapath mux in this block follows
//               "sel ? second : first", so SEL_SECOND picks the second operand.
package circuit2_pipe_pkg;

    localparam int NSTAGES = 3;

    typedef enum logic {
        SEL_FIRST  = 1'b0,
        SEL_SECOND = 1'b1
    } sel_e;

endpackage

// File: rtl/circuit2_pipe_slice.sv
// circuit2_pipe_slice
//   One valid/ready register slice. It holds its payload while stalled and
//   can accept new data on the same edge its current contents leave.
//   Ports:
//     i_clk, i_rst      : clock, asynchronous active-high reset
//     i_valid, o_ready  : upstream handshake
//     i_data            : upstream payload (WIDTH bits)
//     o_valid, i_ready  : downstream handshake
//     o_data            : registered payload (WIDTH bits)
module circuit2_pipe_slice #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Empty, or the current word leaves on this edge.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/circuit2_pipe.sv
// circuit2_pipe
//   Three-stage pipelined x/z datapath over a stream of (a,b,c) triples.
//     stage 1: d = a+b, e = a+c, f = a-b            (modulo 2^DATAWIDTH)
//     stage 2: eq = (d==e), lt = (d<e)
//              g = eq ? e : d, h = lt ? f : g
//     stage 3: x = g << lt, z = h >> lt             (arith shr when SIGNED)
//   Ports:
//     Clk, Rst             : clock, asynchronous active-high reset
//     in_valid, in_ready   : operand handshake
//     a, b, c              : operands (DATAWIDTH bits)
//     out_valid, out_ready : result handshake
//     x, z                 : results (DATAWIDTH bits)
//     res_count            : results accepted by the consumer, wrapping
module circuit2_pipe
    import circuit2_pipe_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter bit SIGNED    = 1'b0,
    parameter int CNTWIDTH  = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] x,
    output logic [DATAWIDTH-1:0] z,
    output logic [CNTWIDTH-1:0]  res_count
);

    localparam int W = DATAWIDTH;

    // Arithmetic components.
    function automatic logic [W-1:0] add_w(input logic [W-1:0] p, input logic [W-1:0] q);
        return p + q;
    endfunction

    function automatic logic [W-1:0] sub_w(input logic [W-1:0] p, input logic [W-1:0] q);
        return p - q;
    endfunction

    function automatic logic comp_lt(input logic [W-1:0] p, input logic [W-1:0] q);
        logic r;
        if (SIGNED) begin
            r = $signed(p) < $signed(q);
        end else begin
            r = p < q;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] shl1(input logic [W-1:0] v, input logic s);
        return s ? {v[W-2:0], 1'b0} : v;
    endfunction

    // Fill bit is built explicitly so no signed/unsigned context mixing can
    // silently turn an arithmetic shift into a logical one.
    function automatic logic [W-1:0] shr1(input logic [W-1:0] v, input logic s);
        logic fill;
        fill = SIGNED ? v[W-1] : 1'b0;
        return s ? {fill, v[W-1:1]} : v;
    endfunction

    // ready[k] is the ready seen by stage k+1's input; ready[NSTAGES] = consumer.
    logic [NSTAGES:0]   w_ready;
    logic [NSTAGES-1:0] w_valid;

    logic [3*W-1:0] w_s1_in,  w_s1_out;
    logic [2*W:0]   w_s2_in,  w_s2_out;
    logic [2*W-1:0] w_s3_in,  w_s3_out;

    logic [W-1:0] w_d, w_e, w_f;
    logic [W-1:0] w_g, w_h, w_g2, w_h2;
    logic         w_eq, w_lt, w_lt2;

    assign w_ready[NSTAGES] = out_ready;
    assign in_ready         = !Rst && w_ready[0];

    // ---- stage 1: sums and difference ----
    assign w_s1_in = {add_w(a, b), add_w(a, c), sub_w(a, b)};

    circuit2_pipe_slice #(.WIDTH(3*W)) u_s1 (
        .i_clk  (Clk),
        .i_rst  (Rst),
        .i_valid(in_valid),
        .o_ready(w_ready[0]),
        .i_data (w_s1_in),
        .o_valid(w_valid[0]),
        .i_ready(w_ready[1]),
        .o_data (w_s1_out)
    );

    // ---- stage 2: compare and select ----
    assign {w_d, w_e, w_f} = w_s1_out;
    assign w_eq = (w_d == w_e);
    assign w_lt = comp_lt(w_d, w_e);
    assign w_g  = (sel_e'(w_eq) == SEL_SECOND) ? w_e : w_d;
    assign w_h  = (sel_e'(w_lt) == SEL_SECOND) ? w_f : w_g;
    assign w_s2_in = {w_g, w_h, w_lt};

    circuit2_pipe_slice #(.WIDTH(2*W+1)) u_s2 (
        .i_clk  (Clk),
        .i_rst  (Rst),
        .i_valid(w_valid[0]),
        .o_ready(w_ready[1]),
        .i_data (w_s2_in),
        .o_valid(w_valid[1]),
        .i_ready(w_ready[2]),
        .o_data (w_s2_out)
    );

    // ---- stage 3: shifts ----
    assign {w_g2, w_h2, w_lt2} = w_s2_out;
    assign w_s3_in = {shl1(w_g2, w_lt2), shr1(w_h2, w_lt2)};

    circuit2_pipe_slice #(.WIDTH(2*W)) u_s3 (
        .i_clk  (Clk),
        .i_rst  (Rst),
        .i_valid(w_valid[1]),
        .o_ready(w_ready[2]),
        .i_data (w_s3_in),
        .o_valid(w_valid[2]),
        .i_ready(w_ready[3]),
        .o_data (w_s3_out)
    );

    assign out_valid = w_valid[2];
    assign {x, z}    = w_s3_out;

    // ---- result counter ----
    logic [CNTWIDTH-1:0] r_count;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_count <= '0;
        end else if (out_valid && out_ready) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign res_count = r_count;

endmodule

// File: tb/tb_circuit2_pipe.sv
// Directed bench for circuit2_pipe. Five instances share one stimulus stream:
//   u0: 32-bit unsigned, u1: 32-bit signed, u2: 8-bit signed,
//   u3: 8-bit unsigned, u4: 32-bit unsigned with a 2-bit result counter.
module tb_circuit2_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0, b = '0, c = '0;

    int total = 0;
    int bad   = 0;

    logic        rdy0, rdy1, rdy2, rdy3, rdy4;
    logic        ov0, ov1, ov2, ov3, ov4;
    logic [31:0] x0, z0, x1, z1, x4, z4;
    logic [7:0]  x2, z2, x3, z3;
    logic [15:0] rc0, rc1, rc2, rc3;
    logic [1:0]  rc4;

    always #5 clk = ~clk;

    circuit2_pipe #(.DATAWIDTH(32), .SIGNED(1'b0), .CNTWIDTH(16)) u0 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .a(a), .b(b), .c(c), .out_valid(ov0), .out_ready(out_ready),
        .x(x0), .z(z0), .res_count(rc0));

    circuit2_pipe #(.DATAWIDTH(32), .SIGNED(1'b1), .CNTWIDTH(16)) u1 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .a(a), .b(b), .c(c), .out_valid(ov1), .out_ready(out_ready),
        .x(x1), .z(z1), .res_count(rc1));

    circuit2_pipe #(.DATAWIDTH(8), .SIGNED(1'b1), .CNTWIDTH(16)) u2 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .a(a[7:0]), .b(b[7:0]), .c(c[7:0]), .out_valid(ov2), .out_ready(out_ready),
        .x(x2), .z(z2), .res_count(rc2));

    circuit2_pipe #(.DATAWIDTH(8), .SIGNED(1'b0), .CNTWIDTH(16)) u3 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(rdy3),
        .a(a[7:0]), .b(b[7:0]), .c(c[7:0]), .out_valid(ov3), .out_ready(out_ready),
        .x(x3), .z(z3), .res_count(rc3));

    circuit2_pipe #(.DATAWIDTH(32), .SIGNED(1'b0), .CNTWIDTH(2)) u4 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .a(a), .b(b), .c(c), .out_valid(ov4), .out_ready(out_ready),
        .x(x4), .z(z4), .res_count(rc4));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        total++; if (ov0 !== 1'b0)     begin bad++; $display("FAIL rst_out_valid got=%0b want=0", ov0); end
        total++; if (x0 !== 32'd0)     begin bad++; $display("FAIL rst_x got=%h want=0", x0); end
        total++; if (z0 !== 32'd0)     begin bad++; $display("FAIL rst_z got=%h want=0", z0); end
        total++; if (rc0 !== 16'd0)    begin bad++; $display("FAIL rst_count got=%0d want=0", rc0); end
        total++; if (rdy0 !== 1'b0)    begin bad++; $display("FAIL rst_in_ready got=%0b want=0", rdy0); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (rdy0 !== 1'b1)    begin bad++; $display("FAIL post_rst_in_ready got=%0b want=1", rdy0); end
    endtask

    task automatic test_basic;
        do_reset();
        a = 32'd5; b = 32'd3; c = 32'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0b want=0", ov0); end
        tick();
        total++; if (ov0 !== 1'b1)   begin bad++; $display("FAIL basic_valid got=%0b want=1", ov0); end
        total++; if (x0 !== 32'd8)   begin bad++; $display("FAIL basic_x got=%h want=8", x0); end
        total++; if (z0 !== 32'd8)   begin bad++; $display("FAIL basic_z got=%h want=8", z0); end
        tick();
        total++; if (rc0 !== 16'd1)  begin bad++; $display("FAIL basic_count got=%0d want=1", rc0); end
        total++; if (ov0 !== 1'b0)   begin bad++; $display("FAIL basic_drain got=%0b want=0", ov0); end
    endtask

    task automatic test_signed_shift;
        do_reset();
        a = 32'd1; b = 32'd2; c = 32'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        total++; if (x0 !== 32'd6)          begin bad++; $display("FAIL uns_x got=%h want=6", x0); end
        total++; if (z0 !== 32'h7FFF_FFFF)  begin bad++; $display("FAIL uns_z got=%h want=7fffffff", z0); end
        total++; if (x1 !== 32'd6)          begin bad++; $display("FAIL sgn_x got=%h want=6", x1); end
        total++; if (z1 !== 32'hFFFF_FFFF)  begin bad++; $display("FAIL sgn_z got=%h want=ffffffff", z1); end
    endtask

    task automatic test_width8;
        do_reset();
        a = 32'h0; b = 32'hFF; c = 32'h1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        total++; if (ov2 !== 1'b1) begin bad++; $display("FAIL w8s_valid got=%0b want=1", ov2); end
        total++; if (x2 !== 8'hFE) begin bad++; $display("FAIL w8s_x got=%h want=fe", x2); end
        total++; if (z2 !== 8'h00) begin bad++; $display("FAIL w8s_z got=%h want=00", z2); end
        total++; if (x3 !== 8'hFF) begin bad++; $display("FAIL w8u_x got=%h want=ff", x3); end
        total++; if (z3 !== 8'hFF) begin bad++; $display("FAIL w8u_z got=%h want=ff", z3); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta [3] = '{32'd5, 32'd1, 32'd10};
        logic [31:0] tb [3] = '{32'd3, 32'd2, 32'd4};
        logic [31:0] tc [3] = '{32'd3, 32'd5, 32'd1};
        logic [31:0] ex [3] = '{32'd8, 32'd6, 32'd14};
        logic [31:0] ez [3] = '{32'd8, 32'h7FFF_FFFF, 32'd14};
        int k;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = ta[i]; b = tb[i]; c = tc[i];
            in_valid = 1'b1;
            total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL b2b_accept%0d got=%0b want=1", i, rdy0); end
            tick();
        end
        in_valid = 1'b0;
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL b2b_full_in_ready got=%0b want=0", rdy0); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ov0 !== 1'b1 || x0 !== 32'd8 || z0 !== 32'd8) begin
                bad++; $display("FAIL b2b_hold%0d got v=%0b x=%h z=%h want v=1 x=8 z=8", i, ov0, x0, z0);
            end
            tick();
        end
        out_ready = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 10 && k < 3; cyc++) begin
            if (ov0 === 1'b1) begin
                total++;
                if (x0 !== ex[k] || z0 !== ez[k]) begin
                    bad++; $display("FAIL b2b_res%0d got x=%h z=%h want x=%h z=%h", k, x0, z0, ex[k], ez[k]);
                end
                k++;
            end
            tick();
        end
        total++; if (k != 3)         begin bad++; $display("FAIL b2b_nres got=%0d want=3", k); end
        total++; if (rc0 !== 16'd3)  begin bad++; $display("FAIL b2b_count got=%0d want=3", rc0); end
        total++; if (ov0 !== 1'b0)   begin bad++; $display("FAIL b2b_empty got=%0b want=0", ov0); end
    endtask

    task automatic test_reset_midflight;
        int seen;
        do_reset();
        a = 32'd5; b = 32'd3; c = 32'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        a = 32'd1; b = 32'd2; c = 32'd5;
        in_valid = 1'b1;
        tick();
        a = 32'd10; b = 32'd4; c = 32'd1;
        tick();
        in_valid = 1'b0;
        total++; if (rc0 !== 16'd1) begin bad++; $display("FAIL mid_pre_count got=%0d want=1", rc0); end
        rst = 1'b1;
        #1;
        total++; if (ov0 !== 1'b0)  begin bad++; $display("FAIL mid_valid got=%0b want=0", ov0); end
        total++; if (x0 !== 32'd0)  begin bad++; $display("FAIL mid_x got=%h want=0", x0); end
        total++; if (z0 !== 32'd0)  begin bad++; $display("FAIL mid_z got=%h want=0", z0); end
        total++; if (rc0 !== 16'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", rc0); end
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ov0 === 1'b1) seen++;
        end
        total++; if (seen != 0)     begin bad++; $display("FAIL mid_stale got=%0d want=0", seen); end
        total++; if (rc0 !== 16'd0) begin bad++; $display("FAIL mid_post_count got=%0d want=0", rc0); end
    endtask

    task automatic test_count_wrap;
        logic [1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic fire;
        int k;
        do_reset();
        a = 32'd5; b = 32'd3; c = 32'd3;
        k = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            in_valid = (cyc < 5);
            fire = ov4 && out_ready;
            tick();
            if (fire && k < 5) begin
                total++;
                if (rc4 !== ec[k]) begin bad++; $display("FAIL wrap%0d got=%0d want=%0d", k, rc4, ec[k]); end
                k++;
            end
        end
        in_valid = 1'b0;
        total++; if (k != 5) begin bad++; $display("FAIL wrap_nres got=%0d want=5", k); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed_shift();
        test_width8();
        test_back_to_back();
        test_reset_midflight();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
